voice_mixer: RTL and testbench
==============================

# voice_mixer

Downstream stage of the per-voice chain (DDS → wavetable → ADSR). Sums the ADSR's signed per-voice samples over one full voice sweep into a wide accumulator. At the last voice it scales and saturates the sum into one output sample. That sample is buffered in a small FIFO and offered to the audio serializer through a valid/ready handshake. The block replaces ad-hoc mixing with a frame-aligned, overflow-safe, back-pressurable sink.

## Interface
Parameters:
- VOICE_BITS, 8, voice index width; voices per frame = 2^VOICE_BITS
- IN_WIDTH, 16, signed per-voice sample width
- OUT_WIDTH, 16, signed mixed output width
- SHIFT, 4, arithmetic right shift applied to the frame sum before saturation
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- i_clk  in  1  single system clock
- i_reset  in  1  asynchronous, active-low reset
- i_pipeline_state  in  2  shared voice pipeline phase (0,1,2; 3 ignored)
- i_voice_index  in  VOICE_BITS  voice currently presented by ADSR
- i_sample  in  IN_WIDTH signed  ADSR output for i_voice_index
- o_sample  out  OUT_WIDTH signed  FIFO head sample
- o_valid  out  1  FIFO non-empty
- i_ready  in  1  consumer accepts o_sample this cycle
- o_clip  out  1  one-cycle pulse: pushed sample was saturated
- o_overflow  out  1  sticky: a frame was dropped because the FIFO was full; cleared only by reset
- o_sync_err  out  1  one-cycle pulse: voice index discontinuity detected
- o_fifo_level  out  clog2(FIFO_DEPTH)+1  entries held

## Operation
- Accumulator width ACC = IN_WIDTH+VOICE_BITS (24 by default); the sign-extended sum cannot overflow.
- Sampling point: only cycles with i_pipeline_state==2. Exactly one accumulate per voice; states 0, 1 and 3 never alter state.
- FSM has two states: SYNC (reset state) and ACCUM.
  - SYNC: wait for a sampling point with i_voice_index==0. On it, acc←sext(i_sample), expected←1, go to ACCUM. All other indices are ignored, which discards a partial first frame.
  - ACCUM, i_voice_index==expected and ≠max: acc←acc+sext(i_sample), expected←expected+1.
  - ACCUM, i_voice_index==expected==2^VOICE_BITS−1: sum=acc+sext(i_sample). Push the result, acc←0, expected←0, stay in ACCUM.
  - ACCUM, i_voice_index≠expected: pulse o_sync_err and discard acc. If the index is 0, restart the frame as SYNC would in the same cycle. Otherwise go to SYNC.
- Result computation: scaled=sum>>>SHIFT, an arithmetic shift that truncates toward −∞. Clamp to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]. Pulse o_clip with the push if clamped.
- FIFO push:
  - Accepted if level<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the new sample is dropped, o_overflow is set, and o_clip is not pulsed.
- FIFO pop: when o_valid && i_ready. Order is strict FIFO. Simultaneous push and pop leaves the level unchanged.
- o_sample reflects the head entry; it is 0 when empty.

## Timing
- Reset (i_reset low, async): FSM=SYNC, acc=0, expected=0, FIFO empty. o_sample=0, o_valid=0, o_clip=0, o_overflow=0, o_sync_err=0, o_fifo_level=0. Reset asserted mid-frame abandons the frame; no partial push.
- Push latency: the result is registered on the clock edge of the last voice's sampling point. o_valid/o_sample update on that same edge, so they are visible the following cycle.
- o_clip and o_sync_err are high for exactly the one cycle after the triggering edge.
- Pop: o_sample advances to the next entry on the edge where valid&&ready. o_valid deasserts on that edge if the FIFO becomes empty.
- Frame period: 3·2^VOICE_BITS clocks (768 by default), so the FIFO drains far faster than it fills under normal ready.
- An index wrap 255→0 is the normal frame boundary and is not a sync error.

## Test plan
- Reset values: hold i_reset low with random inputs → all outputs 0. Release → o_valid stays 0 until a full 0..255 sweep completes.
- Single voice: voice 5 = +1000, all others 0, SHIFT=4, i_ready=1 → one sample 62 per frame, o_clip=0. Voice 5 = −1000 → −63.
- Saturation: all voices +32767 → sum 8388352, >>>4 = 524272 → o_sample 32767, o_clip pulse. All voices −32768 → −32768, o_clip pulse.
- Mid-frame start: release reset with the sweep at index 100 → no push for indices 100..255. First push follows the next complete 0..255 frame with the correct value.
- Back-pressure: i_ready=0 for 5 frames with distinct sums (S1..S5) → level=4, S5 dropped, o_overflow=1 and stays set. Then i_ready=1 → S1..S4 emitted in order on consecutive cycles, o_valid then 0.
- Index skip: sweep jumps 10→12 → o_sync_err pulse, no push for that frame. Resync at the next index 0; the following frame's sum is correct.

Source files
------------

// File: rtl/voice_mixer.sv
// Frame mixer: sums one sweep of per-voice ADSR samples, scales and saturates the
// sum, and queues the result in a small FIFO for the audio serializer.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_SYNC  | waiting for voice 0 at a sampling point; partial frames are dropped
// ST_ACCUM | summing voices in order; the last voice pushes the mixed sample
module voice_mixer #(
  parameter int VOICE_BITS = 8,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [1:0]                    i_pipeline_state,
  input  logic [VOICE_BITS-1:0]         i_voice_index,
  input  logic signed [IN_WIDTH-1:0]    i_sample,
  output logic signed [OUT_WIDTH-1:0]   o_sample,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_clip,
  output logic                          o_overflow,
  output logic                          o_sync_err,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int ACC = IN_WIDTH + VOICE_BITS;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;

  localparam logic [VOICE_BITS-1:0]     VMAX    = '1;
  localparam logic signed [ACC-1:0]     SAT_HI  = {{(ACC-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC-1:0]     SAT_LO  = ~SAT_HI;
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {ST_SYNC, ST_ACCUM} state_t;

  state_t                    state;
  logic signed [ACC-1:0]     acc;
  logic [VOICE_BITS-1:0]     expected;

  logic signed [ACC-1:0]     smp_ext;
  logic signed [ACC-1:0]     sum;
  logic signed [ACC-1:0]     scaled;
  logic                      clamp_hi;
  logic                      clamp_lo;
  logic signed [OUT_WIDTH-1:0] result;
  logic                      sample_pt;
  logic                      match;
  logic                      is_last;
  logic                      push_req;
  logic                      push_ok;
  logic                      pop;
  logic                      full;

  logic [OUT_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]             rd_ptr;
  logic [PW-1:0]             wr_ptr;
  logic [LW-1:0]             level;

  assign smp_ext   = {{VOICE_BITS{i_sample[IN_WIDTH-1]}}, i_sample};
  assign sum       = acc + smp_ext;
  assign scaled    = sum >>> SHIFT;
  assign clamp_hi  = scaled > SAT_HI;
  assign clamp_lo  = scaled < SAT_LO;
  assign result    = clamp_hi ? OUT_MAX : (clamp_lo ? OUT_MIN : scaled[OUT_WIDTH-1:0]);

  assign sample_pt = (i_pipeline_state == 2'd2);
  assign match     = (i_voice_index == expected);
  assign is_last   = (expected == VMAX);
  assign push_req  = sample_pt && (state == ST_ACCUM) && match && is_last;

  assign pop       = (level != '0) && i_ready;
  assign full      = (level == LW'(FIFO_DEPTH));
  // A full FIFO still accepts the new frame when the head leaves on the same edge.
  assign push_ok   = push_req && (!full || pop);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_SYNC;
      acc        <= '0;
      expected   <= '0;
      o_clip     <= 1'b0;
      o_sync_err <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_clip     <= 1'b0;
      o_sync_err <= 1'b0;
      if (sample_pt) begin
        case (state)
          ST_SYNC: begin
            if (i_voice_index == '0) begin
              acc      <= smp_ext;
              expected <= VOICE_BITS'(1);
              state    <= ST_ACCUM;
            end
          end
          ST_ACCUM: begin
            if (match) begin
              if (is_last) begin
                acc      <= '0;
                expected <= '0;
                o_clip   <= push_ok && (clamp_hi || clamp_lo);
                if (!push_ok) o_overflow <= 1'b1;
              end else begin
                acc      <= sum;
                expected <= expected + VOICE_BITS'(1);
              end
            end else begin
              o_sync_err <= 1'b1;
              if (i_voice_index == '0) begin
                acc      <= smp_ext;
                expected <= VOICE_BITS'(1);
              end else begin
                acc      <= '0;
                expected <= '0;
                state    <= ST_SYNC;
              end
            end
          end
          default: state <= ST_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push_ok) - LW'(pop);
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= result;
  end

  assign o_valid      = (level != '0);
  assign o_sample     = o_valid ? mem[rd_ptr] : '0;
  assign o_fifo_level = level;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: frames are driven voice by voice, expected mixes
// are queued on the last voice and compared as the DUT hands them out.
module tb_voice_mixer;

  logic              clk;
  logic              rst_n;
  logic [1:0]        pstate;
  logic [7:0]        vidx;
  logic signed [15:0] smp_in;
  logic signed [15:0] o_sample;
  logic              o_valid;
  logic              i_ready;
  logic              o_clip;
  logic              o_overflow;
  logic              o_sync_err;
  logic [2:0]        o_fifo_level;

  int n_checks = 0;
  int n_pass   = 0;
  int n_sync   = 0;
  int n_clipc  = 0;
  int exp_q[$];
  int smp[256];

  voice_mixer dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_pipeline_state (pstate),
    .i_voice_index    (vidx),
    .i_sample         (smp_in),
    .o_sample         (o_sample),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_clip           (o_clip),
    .o_overflow       (o_overflow),
    .o_sync_err       (o_sync_err),
    .o_fifo_level     (o_fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Consumer side: every accepted handshake must match the oldest queued mix.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_sync_err) n_sync++;
      if (o_clip) n_clipc++;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output_valid", o_valid, 0);
        else chk("out_sample", o_sample, exp_q.pop_front());
      end
    end
  end

  task automatic drive_voice(input int idx, input int val);
    for (int ph = 0; ph < 3; ph++) begin
      @(posedge clk); #1;
      pstate = 2'(ph);
      vidx   = 8'(idx);
      smp_in = (ph == 2) ? 16'(val) : 16'($urandom);
    end
  endtask

  task automatic tick_idle();
    @(posedge clk); #1;
    pstate = 2'd0;
    smp_in = 16'($urandom);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 256; i++) smp[i] = v;
  endtask

  task automatic run_frame(input int start, input int skip_at, input bit exp_push);
    longint sum = 0;
    longint sc;
    bit     clipped = 0;
    bit     accept  = 0;
    for (int i = start; i < 256; i++) begin
      if (i == skip_at) continue;
      sum += smp[i];
      if (i == 255 && exp_push) begin
        sc = sum >>> 4;
        if (sc > 32767) begin sc = 32767; clipped = 1; end
        if (sc < -32768) begin sc = -32768; clipped = 1; end
        accept = (exp_q.size() < 4) || i_ready;
        if (accept) exp_q.push_back(int'(sc));
      end
      drive_voice(i, smp[i]);
      if (skip_at >= 0 && i == skip_at + 1) begin
        tick_idle();
        chk("sync_err_pulse", o_sync_err, 1);
      end
    end
    tick_idle();
    if (exp_push) begin
      chk("clip_flag", o_clip, accept ? clipped : 1'b0);
      if (!accept) chk("overflow_on_drop", o_overflow, 1);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_sample", o_sample, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_clip", o_clip, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_sync_err", o_sync_err, 0);
    chk("rst_level", o_fifo_level, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    i_ready = 1'b1;
    pstate  = 2'd0;
    vidx    = 8'd0;
    smp_in  = 16'sd0;

    // Reset with random inputs toggling.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      pstate  = 2'($urandom_range(0, 3));
      vidx    = 8'($urandom);
      smp_in  = 16'($urandom);
      i_ready = 1'($urandom);
    end
    chk_reset_outputs();
    @(posedge clk); #1;
    pstate  = 2'd0;
    i_ready = 1'b1;
    rst_n   = 1'b1;

    // Single voice, positive and negative (truncation toward -inf).
    set_all(0); smp[5] = 1000;
    run_frame(0, -1, 1);
    set_all(0); smp[5] = -1000;
    run_frame(0, -1, 1);

    // Saturation both ways.
    set_all(32767);
    run_frame(0, -1, 1);
    set_all(-32768);
    run_frame(0, -1, 1);
    tick_idle();
    chk("drained_after_sat", o_valid, 0);

    // Back-pressure: five distinct frames into a four-entry FIFO.
    i_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      set_all(0); smp[5] = 1000 * k; smp[200] = -7 * k;
      run_frame(0, -1, 1);
    end
    chk("bp_level_full", o_fifo_level, 4);
    chk("bp_overflow_set", o_overflow, 1);
    chk("bp_clip_quiet", o_clip, 0);
    i_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_after_drain", o_valid, 0);
    chk("bp_level_after_drain", o_fifo_level, 0);
    chk("bp_overflow_sticky", o_overflow, 1);
    chk("bp_scoreboard_empty", exp_q.size(), 0);

    // Index skip 10 -> 12 aborts the frame; the next full sweep is clean.
    set_all(0); smp[5] = 300;
    run_frame(0, 11, 0);
    tick_idle();
    chk("skip_no_push", o_fifo_level, 0);
    set_all(0); smp[5] = 1600; smp[250] = -16;
    run_frame(0, -1, 1);

    // Reset in the middle of a frame abandons it.
    set_all(0); smp[3] = 5000;
    for (int i = 0; i <= 100; i++) drive_voice(i, smp[i]);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (3) @(posedge clk);
    #1;

    // Release with the sweep already at voice 100.
    rst_n = 1'b1;
    run_frame(100, -1, 0);
    chk("midstart_no_valid", o_valid, 0);
    chk("midstart_level", o_fifo_level, 0);
    set_all(0); smp[0] = 480; smp[255] = -1;
    run_frame(0, -1, 1);
    tick_idle();
    tick_idle();

    chk("sync_err_pulse_count", n_sync, 1);
    chk("clip_pulse_count", n_clipc, 2);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_valid", o_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
